// File: rtl/pwm_duty_decoder.sv
// Measures period and high time of an asynchronous PWM input, decodes the
// generator duty code and flags an input that stops toggling.
module pwm_duty_decoder #(
    parameter int CBITS       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           pwm_in,
    output logic [CBITS:0] period_out,
    output logic [CBITS:0] high_out,
    output logic [2:0]     duty_code,
    output logic           valid,
    output logic           stuck,
    output logic           stuck_level
);

    typedef enum logic [1:0] {
        RESYNC    = 2'd0,
        WAIT_RISE = 2'd1,
        MEASURE   = 2'd2
    } state_t;

    localparam logic [CBITS:0] CNT_MAX  = '1;
    localparam logic [CBITS:0] CNT_ONE  = {{CBITS{1'b0}}, 1'b1};
    localparam logic [CBITS:0] CNT_HALF = {2'b01, {(CBITS-1){1'b0}}};

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES:0]   r_prime;
    logic                   r_pwmD;
    state_t                 r_state;
    state_t                 w_nextState;
    logic [CBITS:0]         r_perCnt;
    logic [CBITS:0]         r_hiCnt;
    logic [CBITS:0]         r_period;
    logic [CBITS:0]         r_high;
    logic [2:0]             r_code;
    logic                   r_valid;
    logic                   r_stuck;
    logic                   r_stuckLevel;

    logic                   w_pwmS;
    logic                   w_rise;
    logic                   w_primed;
    logic                   w_timeout;
    logic                   w_start;
    logic                   w_capture;
    logic                   w_hiInc;
    logic                   w_setStuck;
    logic                   w_clearStuck;
    logic [2:0]             w_code;

    assign w_pwmS   = r_sync[SYNC_STAGES-1];
    assign w_rise   = w_pwmS & ~r_pwmD;
    assign w_primed = r_prime[SYNC_STAGES];
    assign w_code   = (r_hiCnt >= CNT_HALF) ? 3'd7 : r_hiCnt[CBITS-2:CBITS-4];

    // r_prime fills with ones once the synchronizer and edge flop hold real
    // samples, so the zeros left by reset cannot pose as a genuine low phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_prime <= '0;
            r_pwmD  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], pwm_in};
            r_prime <= {r_prime[SYNC_STAGES-1:0], 1'b1};
            r_pwmD  <= w_pwmS;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RESYNC;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            RESYNC:    if (w_primed && !w_pwmS) w_nextState = WAIT_RISE;
            WAIT_RISE: if (w_rise) w_nextState = MEASURE;
            MEASURE:   if (w_timeout) w_nextState = w_pwmS ? RESYNC : WAIT_RISE;
            default:   w_nextState = RESYNC;
        endcase
    end

    // A rise in the same cycle as a saturated period counter wins over timeout.
    always_comb begin
        w_timeout    = (r_perCnt == CNT_MAX) && !w_rise;
        w_start      = 1'b0;
        w_capture    = 1'b0;
        w_hiInc      = 1'b0;
        w_clearStuck = 1'b0;
        w_setStuck   = w_timeout;
        case (r_state)
            WAIT_RISE: begin
                w_start      = w_rise;
                w_clearStuck = w_rise;
            end
            MEASURE: begin
                w_start   = w_rise;
                w_capture = w_rise | w_timeout;
                w_hiInc   = w_pwmS & (r_hiCnt != CNT_MAX);
            end
            default: begin
                w_start = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perCnt <= '0;
            r_hiCnt  <= '0;
        end else begin
            if (w_start) begin
                r_perCnt <= CNT_ONE;
            end else if (w_timeout) begin
                r_perCnt <= '0;
            end else if (r_perCnt != CNT_MAX) begin
                r_perCnt <= r_perCnt + CNT_ONE;
            end

            if (w_start) begin
                r_hiCnt <= CNT_ONE;
            end else if (w_hiInc) begin
                r_hiCnt <= r_hiCnt + CNT_ONE;
            end
        end
    end

    // On a timeout capture the period counter sits at its maximum, so the
    // same path reports either a measured or a saturated period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period     <= '0;
            r_high       <= '0;
            r_code       <= 3'd0;
            r_valid      <= 1'b0;
            r_stuck      <= 1'b0;
            r_stuckLevel <= 1'b0;
        end else begin
            r_valid <= w_capture;
            if (w_capture) begin
                r_period <= r_perCnt;
                r_high   <= r_hiCnt;
                r_code   <= w_code;
            end
            if (w_setStuck) begin
                r_stuck      <= 1'b1;
                r_stuckLevel <= w_pwmS;
            end else if (w_clearStuck) begin
                r_stuck <= 1'b0;
            end
        end
    end

    assign period_out  = r_period;
    assign high_out    = r_high;
    assign duty_code   = r_code;
    assign valid       = r_valid;
    assign stuck       = r_stuck;
    assign stuck_level = r_stuckLevel;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Directed bench for pwm_duty_decoder: three instances (CBITS 16, 8, 4) driven
// one at a time with hand-computed waveforms and expected measurements.
module tb_pwm_duty_decoder;

    logic        clk;
    logic        rst_n;
    logic        pwm16, pwm8, pwm4;

    logic [16:0] per16, high16;
    logic [8:0]  per8, high8;
    logic [4:0]  per4, high4;
    logic [2:0]  code16, code8, code4;
    logic        valid16, valid8, valid4;
    logic        stuck16, stuck8, stuck4;
    logic        level16, level8, level4;

    int          compared = 0;
    int          mismatched = 0;
    int          sel;
    int          validCount;
    logic [16:0] lastPer, lastHigh;
    logic [2:0]  lastCode;

    logic [16:0] obsPer, obsHigh;
    logic [2:0]  obsCode;
    logic        obsValid, obsStuck, obsLevel;

    pwm_duty_decoder #(.CBITS(16), .SYNC_STAGES(2)) dut16 (
        .clk(clk), .rst_n(rst_n), .pwm_in(pwm16),
        .period_out(per16), .high_out(high16), .duty_code(code16),
        .valid(valid16), .stuck(stuck16), .stuck_level(level16)
    );

    pwm_duty_decoder #(.CBITS(8), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .pwm_in(pwm8),
        .period_out(per8), .high_out(high8), .duty_code(code8),
        .valid(valid8), .stuck(stuck8), .stuck_level(level8)
    );

    pwm_duty_decoder #(.CBITS(4), .SYNC_STAGES(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .pwm_in(pwm4),
        .period_out(per4), .high_out(high4), .duty_code(code4),
        .valid(valid4), .stuck(stuck4), .stuck_level(level4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        obsPer   = '0;
        obsHigh  = '0;
        obsCode  = 3'd0;
        obsValid = 1'b0;
        obsStuck = 1'b0;
        obsLevel = 1'b0;
        case (sel)
            0: begin
                obsPer = per16; obsHigh = high16; obsCode = code16;
                obsValid = valid16; obsStuck = stuck16; obsLevel = level16;
            end
            1: begin
                obsPer = {8'd0, per8}; obsHigh = {8'd0, high8}; obsCode = code8;
                obsValid = valid8; obsStuck = stuck8; obsLevel = level8;
            end
            default: begin
                obsPer = {12'd0, per4}; obsHigh = {12'd0, high4}; obsCode = code4;
                obsValid = valid4; obsStuck = stuck4; obsLevel = level4;
            end
        endcase
    end

    // One clock of the selected waveform; outputs are sampled on the falling edge.
    task automatic applyStimulus(input logic level);
        case (sel)
            0:       pwm16 = level;
            1:       pwm8  = level;
            default: pwm4  = level;
        endcase
        @(posedge clk);
        @(negedge clk);
        if (obsValid === 1'b1) begin
            validCount++;
            lastPer  = obsPer;
            lastHigh = obsHigh;
            lastCode = obsCode;
        end
    endtask

    task automatic holdLevel(input logic level, input int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus(level);
    endtask

    task automatic runWave(input int period, input int high, input int count);
        for (int p = 0; p < count; p++)
            for (int i = 0; i < period; i++)
                applyStimulus(i < high);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    initial begin
        sel = 0;
        validCount = 0;
        lastPer = '0;
        lastHigh = '0;
        lastCode = 3'd0;
        pwm16 = 1'b0;
        pwm8 = 1'b0;
        pwm4 = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);

        checkOutput("rst_period16", per16, 0);
        checkOutput("rst_high16", high16, 0);
        checkOutput("rst_code16", code16, 0);
        checkOutput("rst_valid16", valid16, 0);
        checkOutput("rst_stuck16", stuck16, 0);
        checkOutput("rst_level16", level16, 0);
        checkOutput("rst_period8", per8, 0);
        checkOutput("rst_period4", per4, 0);
        rst_n = 1'b1;

        // Period 16, high 4 on CBITS=16: the first rise only arms the measurement.
        $display("[TB] period 16 high 4 on CBITS=16");
        sel = 0;
        holdLevel(1'b0, 10);
        validCount = 0;
        runWave(16, 4, 1);
        checkOutput("first_rise_no_valid", validCount, 0);
        runWave(16, 4, 4);
        checkOutput("p16_valid_count", validCount, 4);
        checkOutput("p16_period", lastPer, 16);
        checkOutput("p16_high", lastHigh, 4);
        checkOutput("p16_code", lastCode, 0);
        checkOutput("p16_stuck", obsStuck, 0);

        $display("[TB] period 256 on CBITS=8");
        sel = 1;
        holdLevel(1'b0, 4);
        validCount = 0;
        runWave(256, 48, 3);
        checkOutput("h48_valid_count", validCount, 2);
        checkOutput("h48_period", lastPer, 256);
        checkOutput("h48_high", lastHigh, 48);
        checkOutput("h48_code", lastCode, 3);
        checkOutput("h48_stuck", obsStuck, 0);
        runWave(256, 112, 2);
        checkOutput("h112_high", lastHigh, 112);
        checkOutput("h112_code", lastCode, 7);
        runWave(256, 128, 2);
        checkOutput("h128_high", lastHigh, 128);
        checkOutput("h128_code", lastCode, 7);
        runWave(256, 16, 2);
        checkOutput("h16_period", lastPer, 256);
        checkOutput("h16_code", lastCode, 1);

        $display("[TB] held low from reset on CBITS=4");
        sel = 2;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        validCount = 0;
        holdLevel(1'b0, 30);
        checkOutput("low_not_yet_stuck", obsStuck, 0);
        holdLevel(1'b0, 3);
        checkOutput("low_stuck", obsStuck, 1);
        checkOutput("low_stuck_level", obsLevel, 0);
        checkOutput("low_no_valid", validCount, 0);
        runWave(8, 2, 1);
        checkOutput("stuck_cleared", obsStuck, 0);
        checkOutput("arm_no_valid", validCount, 0);
        runWave(8, 2, 2);
        checkOutput("p8_valid_count", validCount, 2);
        checkOutput("p8_period", lastPer, 8);
        checkOutput("p8_high", lastHigh, 2);
        checkOutput("p8_code", lastCode, 2);

        $display("[TB] held high while measuring on CBITS=4");
        validCount = 0;
        holdLevel(1'b1, 50);
        checkOutput("high_valid_count", validCount, 2);
        checkOutput("high_period", lastPer, 31);
        checkOutput("high_high", lastHigh, 31);
        checkOutput("high_code", lastCode, 7);
        checkOutput("high_stuck", obsStuck, 1);
        checkOutput("high_stuck_level", obsLevel, 1);
        validCount = 0;
        holdLevel(1'b1, 40);
        checkOutput("resync_no_valid", validCount, 0);
        holdLevel(1'b0, 6);
        runWave(8, 2, 2);
        checkOutput("recover_valid_count", validCount, 1);
        checkOutput("recover_period", lastPer, 8);
        checkOutput("recover_stuck", obsStuck, 0);

        $display("[TB] period at the counter limit on CBITS=4");
        validCount = 0;
        runWave(31, 5, 3);
        checkOutput("p31_valid_count", validCount, 3);
        checkOutput("p31_period", lastPer, 31);
        checkOutput("p31_high", lastHigh, 5);
        checkOutput("p31_code", lastCode, 5);
        checkOutput("p31_stuck", obsStuck, 0);
        validCount = 0;
        runWave(32, 5, 2);
        checkOutput("p32_valid_count", validCount, 2);
        checkOutput("p32_period", lastPer, 31);
        checkOutput("p32_stuck_before", obsStuck, 0);
        holdLevel(1'b0, 4);
        checkOutput("p32_timeout_valid", validCount, 3);
        checkOutput("p32_stuck_after", obsStuck, 1);
        checkOutput("p32_stuck_level", obsLevel, 0);

        $display("[TB] reset mid-period with input high on CBITS=4");
        holdLevel(1'b1, 3);
        rst_n = 1'b0;
        holdLevel(1'b1, 2);
        checkOutput("midrst_period", per4, 0);
        checkOutput("midrst_high", high4, 0);
        checkOutput("midrst_code", code4, 0);
        checkOutput("midrst_valid", valid4, 0);
        checkOutput("midrst_stuck", stuck4, 0);
        checkOutput("midrst_level", level4, 0);
        rst_n = 1'b1;
        validCount = 0;
        holdLevel(1'b1, 3);
        holdLevel(1'b0, 4);
        holdLevel(1'b1, 4);
        holdLevel(1'b0, 4);
        checkOutput("midrst_no_early_valid", validCount, 0);
        holdLevel(1'b1, 4);
        holdLevel(1'b0, 4);
        checkOutput("midrst_valid_count", validCount, 1);
        checkOutput("midrst_period_meas", lastPer, 8);
        checkOutput("midrst_high_meas", lastHigh, 4);
        checkOutput("midrst_code_meas", lastCode, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
